// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM upload/restore paths.
package nvram_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitWin,
        StIssue,
        StCapture
    } nvram_state_e;

    localparam logic [7:0] NVRAM_INDEX = 8'd4;
    localparam logic [7:0] FILL        = 8'hFF;

endpackage

// File: rtl/nvram_port_arb.sv
// Work-RAM port borrowing: grants only on idle vblank cycles and holds the grant
// until the owner drops it, regardless of what the CPU does in the meantime.
module nvram_port_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic drop,
    input  logic v_blank,
    input  logic cpu_mem_active,
    output logic grant,
    output logic sel
);

    assign grant = req && v_blank && !cpu_mem_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= 1'b0;
        end else if (drop) begin
            sel <= 1'b0;
        end else if (grant) begin
            sel <= 1'b1;
        end
    end

endmodule

// File: rtl/nvram_upload_reader.sv
// Serves HPS upload reads of the NVRAM window, stalling ioctl_wait until the byte
// has been fetched from work RAM during an idle vblank cycle.
module nvram_upload_reader
    import nvram_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned SIZE   = 256,
    parameter logic [15:0] BASE   = 16'h0000,
    parameter logic [7:0]  INDEX  = NVRAM_INDEX
) (
    input  logic        CLK_4M,
    input  logic        nRESET,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    input  logic        V_BLANK,
    input  logic        cpu_mem_active,
    output logic        ram_sel,
    output logic [15:0] ram_addr,
    input  logic [7:0]  ram_dout,
    output logic        busy,
    output logic        done
);

    localparam logic [24:0]       SizeLim = 25'(SIZE);
    localparam logic [ADDR_W-1:0] LastOff = ADDR_W'(SIZE - 1);

    nvram_state_e      state_q;
    logic [ADDR_W-1:0] offset_q;
    logic              active;
    logic              arb_req;
    logic              arb_drop;
    logic              grant;

    assign active   = ioctl_upload && (ioctl_index == INDEX);
    assign arb_req  = (state_q == StWaitWin) && active;
    // Release the port after the capture edge, or at once if the session goes away.
    assign arb_drop = !active || (state_q == StCapture);
    assign busy     = (state_q != StIdle);

    nvram_port_arb u_arb (
        .clk            (CLK_4M),
        .rst_n          (nRESET),
        .req            (arb_req),
        .drop           (arb_drop),
        .v_blank        (V_BLANK),
        .cpu_mem_active (cpu_mem_active),
        .grant          (grant),
        .sel            (ram_sel)
    );

    always_ff @(posedge CLK_4M or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= StIdle;
            offset_q   <= '0;
            ioctl_din  <= FILL;
            ioctl_wait <= 1'b0;
            ram_addr   <= BASE;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_q != StIdle && !active) begin
                // Abort: ioctl_din deliberately keeps its last value.
                state_q    <= StIdle;
                ioctl_wait <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (ioctl_rd && active) begin
                            if (ioctl_addr < SizeLim) begin
                                offset_q   <= ioctl_addr[ADDR_W-1:0];
                                ioctl_wait <= 1'b1;
                                state_q    <= StWaitWin;
                            end else begin
                                ioctl_din <= FILL;
                            end
                        end
                    end
                    StWaitWin: begin
                        if (grant) begin
                            ram_addr <= BASE + 16'(offset_q);
                            state_q  <= StIssue;
                        end
                    end
                    StIssue: begin
                        state_q <= StCapture;
                    end
                    StCapture: begin
                        ioctl_din  <= ram_dout;
                        ioctl_wait <= 1'b0;
                        done       <= (offset_q == LastOff);
                        state_q    <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/nvram_upload_reader.md
Name: nvram_upload_reader

Overview:
- Serves HPS upload (save) requests: the HPS reads the game's hiscore/NVRAM bytes out of the core over the ioctl upload channel.
- It is the read-side counterpart of the ROM download path, where the HPS writes into the core.
- Sits beside hps_io in the emu top and borrows the single-port work RAM from the CPU only on idle vblank cycles.
- Holds ioctl_wait until each requested byte is valid on ioctl_din.

Parameters:
- ADDR_W, 8, width of the NVRAM window address (window holds 2^ADDR_W bytes)
- SIZE, 256, number of valid bytes; requires SIZE <= 2^ADDR_W
- BASE, 16'h0000, work-RAM base address of the window
- INDEX, 8'd4, ioctl_index value that selects this block

Ports:
- CLK_4M  in  1  system clock (clk_sys)
- nRESET  in  1  asynchronous active-low reset
- ioctl_upload  in  1  HPS upload session active
- ioctl_index  in  8  session file index
- ioctl_rd  in  1  one-cycle read strobe from HPS
- ioctl_addr  in  25  byte address of the read
- ioctl_din  out  8  byte returned to HPS
- ioctl_wait  out  1  high while the byte is not yet valid
- V_BLANK  in  1  vertical blank from the video timing
- cpu_mem_active  in  1  CPU is using work RAM this cycle
- ram_sel  out  1  when high, the top muxes the RAM port to this block
- ram_addr  out  16  RAM address (BASE + offset)
- ram_dout  in  8  RAM read data, valid 1 cycle after the address is presented
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when byte SIZE-1 has been returned

Behaviour:
- Reset values: ioctl_din=8'hFF, ioctl_wait=0, ram_sel=0, ram_addr=BASE, busy=0, done=0, state=IDLE.
- active = ioctl_upload && (ioctl_index==INDEX).
- States: IDLE, WAIT_WIN, ISSUE, CAPTURE.
- IDLE:
  - ioctl_rd && active && ioctl_addr < SIZE: latch offset = ioctl_addr[ADDR_W-1:0]; set ioctl_wait=1 on the next edge; go to WAIT_WIN.
  - ioctl_rd && active && ioctl_addr >= SIZE: ioctl_din <= 8'hFF on the next edge; ioctl_wait stays 0; stay in IDLE.
  - ioctl_rd while not active: ignored.
- WAIT_WIN: on a cycle where V_BLANK=1 && cpu_mem_active=0, drive ram_sel=1 and ram_addr=BASE+offset (registered); go to ISSUE.
- ISSUE: hold ram_sel and ram_addr for one cycle so the RAM's 1-cycle read latency completes; go to CAPTURE.
- CAPTURE:
  - ioctl_din <= ram_dout; ram_sel <= 0; ioctl_wait <= 0; return to IDLE.
  - If offset == SIZE-1, pulse done in the same cycle.
- Latency: the best case from the ioctl_rd cycle to ioctl_wait falling is 4 edges. There is no upper bound; the block waits for a window indefinitely.
- Once ram_sel is asserted, the access completes even if V_BLANK falls or cpu_mem_active rises. The top gives ram_sel priority, and the CPU side stalls for those at most 2 cycles.
- ioctl_rd arriving while busy: ignored; no re-latch of the offset.
- Abort: active falls in any state other than IDLE. Next edge: ram_sel=0, ioctl_wait=0, no done pulse, state=IDLE. ioctl_din keeps its last value.
- Reset mid-operation: all outputs return to reset values immediately (async).
- Offset arithmetic: ram_addr = BASE + zero-extended offset, 16-bit, wraps modulo 2^16.
- ioctl_din changes only in CAPTURE, on an out-of-range read, or on reset.

Decomposition:
- Shared package nvram_pkg holds:
  - state enum (IDLE, WAIT_WIN, ISSUE, CAPTURE)
  - localparam NVRAM_INDEX = 8'd4
  - fill byte FILL = 8'hFF
- Natural sub-module: nvram_port_arb. It is the combinational-plus-registered grant logic that produces ram_sel from V_BLANK, cpu_mem_active and the request, and the top reuses it for a later NVRAM restore (download) path.

Test Plan:
- Reset with ioctl_rd pulsing -> ioctl_din=FF, ioctl_wait=0, ram_sel=0 throughout reset.
- V_BLANK=1, cpu_mem_active=0, RAM[BASE+5]=8'h3C, ioctl_rd addr=5 -> ram_sel high for exactly 2 cycles, ram_addr=BASE+5, ioctl_din=3C, ioctl_wait low 4 edges after the strobe.
- ioctl_rd addr=7 with V_BLANK=0 for 100 cycles, then V_BLANK=1 with cpu_mem_active=1 for 3 cycles, then 0 -> ram_sel never asserted early; returns RAM[BASE+7] after the window opens.
- Sequential reads addr 0..255 -> all bytes match the RAM image; done pulses once, on addr 255; read addr 300 -> ioctl_din=FF with no wait.
- ioctl_upload dropped during WAIT_WIN and again during ISSUE -> ioctl_wait and ram_sel low next edge, no done pulse, a following read succeeds normally.
- Wrong ioctl_index (8'd0) with ioctl_rd -> no state change, ioctl_wait stays 0.
